// File: rtl/homenc_mem_loader.sv
// homenc_mem_loader: host-side transfer engine feeding the homenc_coprocessor
// CPU memory port. One command moves a burst of 512-bit words into
// coprocessor memory blocks (write) or returns a burst from one block
// through a skid FIFO with backpressure (read).
module homenc_mem_loader #(
  parameter int unsigned RD_LAT     = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic         cmd_write,
  input  logic [6:0]   cmd_strobe,
  input  logic         cmd_all,
  input  logic [10:0]  cmd_addr,
  input  logic [11:0]  cmd_len,
  input  logic [511:0] s_data,
  input  logic         s_valid,
  output logic         s_ready,
  output logic [511:0] m_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic         cpu_interrupt,
  output logic [6:0]   cpu_mb_strobe,
  output logic         cpu_mb_all,
  output logic [3:0]   cpu_mem_sel,
  output logic [10:0]  cpu_mem_addr,
  output logic [511:0] cpu_mem_wr_data,
  output logic         cpu_mem_wr_en,
  input  logic [511:0] cpu_mem_rd_data
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_WRITE,
    ST_READ,
    ST_DRAIN,
    ST_FINISH
  } state_e;

  state_e state_q, state_d;

  logic          write_q, write_d;
  logic [6:0]    strobe_q, strobe_d;
  logic          all_q, all_d;
  logic [10:0]   addr_q, addr_d;
  logic [11:0]   rem_q, rem_d;
  logic          err_q, err_d;
  logic [RD_LAT-1:0] pipe_q, pipe_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [511:0]  fifo_mem_q [FIFO_DEPTH];

  logic          cmd_fire;
  logic          cmd_bad;
  logic          s_fire;
  logic          issue;
  logic          capture;
  logic          pop;
  logic [CW:0]   occ_sum;
  logic [12:0]   end_sum;
  logic          strobe_onehot;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(FIFO_DEPTH - 1)) return '0;
    return p + PW'(1);
  endfunction

  // Command validation: range check, zero length, and read-only restrictions
  always_comb begin
    end_sum       = {2'b00, cmd_addr} + {1'b0, cmd_len};
    strobe_onehot = (cmd_strobe != '0) && ((cmd_strobe & (cmd_strobe - 7'd1)) == '0);
    cmd_fire      = cmd_valid && (state_q == ST_IDLE);
    cmd_bad       = (cmd_len == '0) || (end_sum > 13'd2048) ||
                    (!cmd_write && (cmd_all || !strobe_onehot));
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (cmd_fire && !cmd_bad) state_d = ST_ARM;
      ST_ARM:    state_d = write_q ? ST_WRITE : ST_READ;
      ST_WRITE:  if (s_fire && (rem_q == 12'd1)) state_d = ST_FINISH;
      ST_READ:   if (issue && (rem_q == 12'd1)) state_d = ST_DRAIN;
      ST_DRAIN:  if ((out_q == '0) && (fifo_cnt_q == '0)) state_d = ST_FINISH;
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output and handshake decode from the current state
  always_comb begin
    cmd_ready       = (state_q == ST_IDLE);
    busy            = (state_q != ST_IDLE);
    done            = (state_q == ST_FINISH);
    err             = err_q;
    cpu_interrupt   = (state_q == ST_ARM) || (state_q == ST_WRITE) ||
                      (state_q == ST_READ) || (state_q == ST_DRAIN);
    cpu_mem_sel     = 4'd4;
    cpu_mb_strobe   = cpu_interrupt ? strobe_q : '0;
    cpu_mb_all      = cpu_interrupt ? all_q : 1'b0;
    cpu_mem_addr    = cpu_interrupt ? addr_q : '0;
    s_ready         = (state_q == ST_WRITE);
    s_fire          = s_ready && s_valid;
    cpu_mem_wr_en   = s_fire;
    cpu_mem_wr_data = '0;
    if (s_fire) begin
      cpu_mem_wr_data = s_data;
      // Top nibble of each of lanes 0..6 and the whole of lane 7 never reach memory
      for (int unsigned k = 0; k < 7; k++) cpu_mem_wr_data[64*k+60 +: 4] = '0;
      cpu_mem_wr_data[511:448] = '0;
    end
    occ_sum  = {1'b0, out_q} + {1'b0, fifo_cnt_q};
    issue    = (state_q == ST_READ) && (rem_q != '0) &&
               (occ_sum < (CW+1)'(FIFO_DEPTH));
    capture  = pipe_q[RD_LAT-1];
    m_valid  = (fifo_cnt_q != '0);
    m_data   = m_valid ? fifo_mem_q[rd_ptr_q] : '0;
    pop      = m_valid && m_ready;
  end

  // Datapath next values: command latch, address/count stepping, read tracking
  always_comb begin
    write_d    = write_q;
    strobe_d   = strobe_q;
    all_d      = all_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    err_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_fire) begin
          if (cmd_bad) begin
            err_d = 1'b1;
          end else begin
            write_d  = cmd_write;
            strobe_d = cmd_strobe;
            all_d    = cmd_all;
            addr_d   = cmd_addr;
            rem_d    = cmd_len;
          end
        end
      end
      ST_WRITE: begin
        if (s_fire) begin
          addr_d = addr_q + 11'd1;
          rem_d  = rem_q - 12'd1;
        end
      end
      ST_READ: begin
        if (issue) begin
          addr_d = addr_q + 11'd1;
          rem_d  = rem_q - 12'd1;
        end
      end
      ST_FINISH: begin
        strobe_d = '0;
        all_d    = 1'b0;
      end
      default: ;
    endcase

    // The issue pipe mirrors the memory read latency; its tail marks a valid return
    pipe_d = '0;
    pipe_d[0] = issue;
    for (int unsigned i = 1; i < RD_LAT; i++) pipe_d[i] = pipe_q[i-1];

    out_d      = out_q + CW'(issue) - CW'(capture);
    fifo_cnt_d = fifo_cnt_q + CW'(capture) - CW'(pop);
    wr_ptr_d   = capture ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d   = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_q    <= 1'b0;
      strobe_q   <= '0;
      all_q      <= 1'b0;
      addr_q     <= '0;
      rem_q      <= '0;
      err_q      <= 1'b0;
      pipe_q     <= '0;
      out_q      <= '0;
      fifo_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      write_q    <= write_d;
      strobe_q   <= strobe_d;
      all_q      <= all_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      err_q      <= err_d;
      pipe_q     <= pipe_d;
      out_q      <= out_d;
      fifo_cnt_q <= fifo_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Skid FIFO storage; occupancy is tracked by the reset counters above
  always_ff @(posedge clk) begin
    if (capture) fifo_mem_q[wr_ptr_q] <= cpu_mem_rd_data;
  end

endmodule

// File: tb/tb_homenc_mem_loader.sv
// Self-checking bench for homenc_mem_loader: write/read scoreboards, a
// latency-2 coprocessor memory model, illegal commands and async reset.
module tb_homenc_mem_loader;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid, cmd_ready, cmd_write, cmd_all;
  logic [6:0]   cmd_strobe;
  logic [10:0]  cmd_addr;
  logic [11:0]  cmd_len;
  logic [511:0] s_data;
  logic         s_valid, s_ready;
  logic [511:0] m_data;
  logic         m_valid, m_ready;
  logic         busy, done, err;
  logic         cpu_interrupt;
  logic [6:0]   cpu_mb_strobe;
  logic         cpu_mb_all;
  logic [3:0]   cpu_mem_sel;
  logic [10:0]  cpu_mem_addr;
  logic [511:0] cpu_mem_wr_data;
  logic         cpu_mem_wr_en;
  logic [511:0] cpu_mem_rd_data;

  homenc_mem_loader #(.RD_LAT(2), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_strobe(cmd_strobe), .cmd_all(cmd_all), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .busy(busy), .done(done), .err(err),
    .cpu_interrupt(cpu_interrupt), .cpu_mb_strobe(cpu_mb_strobe), .cpu_mb_all(cpu_mb_all),
    .cpu_mem_sel(cpu_mem_sel), .cpu_mem_addr(cpu_mem_addr),
    .cpu_mem_wr_data(cpu_mem_wr_data), .cpu_mem_wr_en(cpu_mem_wr_en),
    .cpu_mem_rd_data(cpu_mem_rd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0]  addr;
    logic [511:0] data;
  } wexp_t;

  wexp_t        wq[$];
  logic [511:0] rq[$];

  int n_cmp = 0;
  int n_bad = 0;
  int int_cycles, busy_cycles, done_cnt, err_cnt, wr_cnt;
  logic [6:0]  exp_strobe;
  logic        exp_all;
  logic [10:0] exp_next_addr;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Coprocessor memory model: data for an address is valid two cycles later
  function automatic logic [511:0] mdata(input logic [10:0] a);
    logic [511:0] r;
    for (int k = 0; k < 16; k++) r[32*k +: 32] = {a, 5'(k), 16'h5A5A};
    return r;
  endfunction

  logic [10:0] a1 = '0, a2 = '0;
  always @(posedge clk) begin
    a1 <= cpu_mem_addr;
    a2 <= a1;
  end
  always_comb cpu_mem_rd_data = mdata(a2);

  function automatic logic [511:0] mkdata(input int i);
    logic [511:0] r;
    for (int k = 0; k < 7; k++) r[64*k +: 64] = {4'hF, 60'(i + k*4096)};
    r[511:448] = '1;
    return r;
  endfunction

  function automatic logic [511:0] wexp(input int i);
    logic [511:0] r;
    r = '0;
    for (int k = 0; k < 7; k++) r[64*k +: 64] = {4'h0, 60'(i + k*4096)};
    return r;
  endfunction

  // Output monitor: pops scoreboards and tallies framing signals
  initial begin
    wexp_t e;
    logic [511:0] x;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (cpu_interrupt) begin
          int_cycles++;
          chk("mb_strobe", cpu_mb_strobe, exp_strobe);
          chk("mb_all", cpu_mb_all, exp_all);
        end
        if (busy) busy_cycles++;
        if (done) done_cnt++;
        if (err) err_cnt++;
        if (cpu_mem_wr_en) begin
          wr_cnt++;
          chk("wr_needs_valid", s_valid, 1);
          if (wq.size() == 0) chk("wr_unexpected", 1, 0);
          else begin
            e = wq.pop_front();
            chk("wr_addr", cpu_mem_addr, e.addr);
            chk("wr_data", cpu_mem_wr_data, e.data);
          end
          exp_next_addr = exp_next_addr + 11'd1;
        end else if (cpu_interrupt && s_ready) begin
          chk("wr_hold_addr", cpu_mem_addr, exp_next_addr);
        end
        if (m_valid && m_ready) begin
          if (rq.size() == 0) chk("rd_extra", 1, 0);
          else begin
            x = rq.pop_front();
            chk("rd_data", m_data, x);
          end
        end
      end
    end
  end

  task automatic clr();
    int_cycles = 0; busy_cycles = 0; done_cnt = 0; err_cnt = 0; wr_cnt = 0;
  endtask

  task automatic send_cmd(input logic w, input logic [6:0] strobe, input logic all,
                          input logic [10:0] addr, input logic [11:0] len);
    @(posedge clk); #1;
    chk("cmd_ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = w; cmd_strobe = strobe; cmd_all = all;
    cmd_addr = addr; cmd_len = len;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < budget);
    if (busy) chk("idle_timeout", busy, 0);
  endtask

  task automatic do_write(input logic [10:0] addr, input int len, input logic [6:0] strobe,
                          input logic all, input bit gaps, input int abort);
    int i = 0, c = 0, presented = -1;
    wexp_t e;
    clr();
    exp_strobe = strobe; exp_all = all; exp_next_addr = addr;
    send_cmd(1'b1, strobe, all, addr, 12'(len));
    while (i < len && c < 10000) begin
      if (!gaps || (c % 3 == 0)) begin
        s_data = mkdata(i); s_valid = 1'b1;
        if (presented != i) begin
          e.addr = addr + 11'(i); e.data = wexp(i);
          wq.push_back(e);
          presented = i;
        end
      end else s_valid = 1'b0;
      @(negedge clk);
      if (c == 0) begin
        chk("arm_int", cpu_interrupt, 1);
        chk("arm_addr", cpu_mem_addr, addr);
        chk("arm_wr_en", cpu_mem_wr_en, 0);
      end
      if (s_valid && s_ready) i++;
      if (abort != 0 && i == abort) begin
        #2 rst = 1'b1;
        #1;
        chk("rst_int", cpu_interrupt, 0);
        chk("rst_wr_en", cpu_mem_wr_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        s_valid = 1'b0;
        wq.delete();
        @(posedge clk); @(posedge clk); #3 rst = 1'b0;
        return;
      end
      @(posedge clk); #1;
      c++;
    end
    s_valid = 1'b0;
    if (i < len) chk("wr_timeout", i, len);
    wait_idle(50);
    chk("wr_count", wr_cnt, len);
    chk("wr_done", done_cnt, 1);
    chk("wr_queue_empty", wq.size(), 0);
    if (!gaps) chk("wr_int_cycles", int_cycles, len + 1);
  endtask

  task automatic do_read(input logic [10:0] addr, input int len, input logic [6:0] strobe);
    int c = 0;
    clr();
    exp_strobe = strobe; exp_all = 1'b0; exp_next_addr = addr;
    for (int i = 0; i < len; i++) rq.push_back(mdata(addr + 11'(i)));
    send_cmd(1'b0, strobe, 1'b0, addr, 12'(len));
    @(negedge clk);
    chk("rd_arm_int", cpu_interrupt, 1);
    chk("rd_arm_addr", cpu_mem_addr, addr);
    while (rq.size() > 0 && c < 400) begin
      @(posedge clk); #1;
      m_ready = (c % 2 == 0);
      c++;
    end
    if (rq.size() > 0) chk("rd_timeout", rq.size(), 0);
    m_ready = 1'b0;
    wait_idle(50);
    chk("rd_done", done_cnt, 1);
    chk("rd_m_valid_end", m_valid, 0);
    chk("rd_no_writes", wr_cnt, 0);
  endtask

  task automatic illegal(input string tag, input logic w, input logic [6:0] strobe,
                         input logic all, input logic [10:0] addr, input logic [11:0] len);
    clr();
    send_cmd(w, strobe, all, addr, len);
    @(negedge clk);
    chk({tag, "_err"}, err, 1);
    repeat (3) @(negedge clk);
    chk({tag, "_err_cnt"}, err_cnt, 1);
    chk({tag, "_int"}, int_cycles, 0);
    chk({tag, "_busy"}, busy_cycles, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_strobe = '0; cmd_all = 1'b0;
    cmd_addr = '0; cmd_len = '0; s_data = '0; s_valid = 1'b0; m_ready = 1'b0;
    exp_strobe = '0; exp_all = 1'b0; exp_next_addr = '0;
    clr();
    #3;
    chk("rst_cmd_ready0", cmd_ready, 1);
    chk("rst_sel", cpu_mem_sel, 4);
    chk("rst_busy0", busy, 0);
    chk("rst_int0", cpu_interrupt, 0);
    chk("rst_outs", {done, err, s_ready, m_valid, cpu_mem_wr_en, cpu_mb_all}, 0);
    chk("rst_strobe", cpu_mb_strobe, 0);
    #19 rst = 1'b0;

    do_write(11'd0, 2048, 7'b1010101, 1'b0, 1'b0, 0);
    do_write(11'd300, 8, 7'b0000010, 1'b0, 1'b1, 0);
    do_read(11'd100, 16, 7'b0000100);
    illegal("len0", 1'b1, 7'b0000001, 1'b0, 11'd0, 12'd0);
    illegal("range", 1'b1, 7'b0000001, 1'b0, 11'd2040, 12'd16);
    illegal("rd_multi", 1'b0, 7'b0000011, 1'b0, 11'd0, 12'd4);
    illegal("rd_all", 1'b0, 7'b0000001, 1'b1, 11'd0, 12'd4);
    do_write(11'd2040, 8, 7'b1111111, 1'b0, 1'b0, 0);
    do_write(11'd0, 2048, 7'b0000001, 1'b0, 1'b0, 500);
    do_write(11'd1000, 4, 7'b0001000, 1'b0, 1'b0, 0);
    do_write(11'd7, 2, 7'b0000001, 1'b1, 1'b0, 0);
    do_read(11'd2047, 1, 7'b1000000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/homenc_mem_loader.md
Name: homenc_mem_loader

Overview:
- Host-side transfer engine directly upstream of homenc_coprocessor's CPU memory port.
- Accepts one transfer command plus a 512-bit data stream and drives the cpu_* signals: interrupt framing, block strobe, addresses and write-enables.
- Write commands move streamed words into coprocessor memory blocks.
- Read commands fetch words from one block and return them on an output stream with backpressure.

Parameters:
- RD_LAT, 2, cycles from cpu_mem_addr presentation to valid cpu_mem_rd_data.
- FIFO_DEPTH, 4, read skid FIFO entries; must be >= RD_LAT+1.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  high only in IDLE
- cmd_write  in  1  1=write, 0=read
- cmd_strobe  in  7  target memory block(s)
- cmd_all  in  1  broadcast write to all processors
- cmd_addr  in  11  start word address
- cmd_len  in  12  word count, 1..2048
- s_data  in  512  write data
- s_valid  in  1  write data valid
- s_ready  out  1  write data accepted
- m_data  out  512  read data
- m_valid  out  1  read data valid
- m_ready  in  1  read data consumed
- busy  out  1  not IDLE
- done  out  1  one-cycle pulse at transfer end
- err  out  1  one-cycle pulse on rejected command
- cpu_interrupt  out  1  access window to coprocessor
- cpu_mb_strobe  out  7  latched cmd_strobe
- cpu_mb_all  out  1  latched cmd_all
- cpu_mem_sel  out  4  constant 4
- cpu_mem_addr  out  11  word address
- cpu_mem_wr_data  out  512  masked write data
- cpu_mem_wr_en  out  1  write strobe
- cpu_mem_rd_data  in  512  read data from coprocessor

Behaviour:
- Reset (async, any state): state IDLE; all outputs 0 except cmd_ready=1 and cpu_mem_sel=4; FIFO empty; outstanding count 0. Reset mid-transfer drops cpu_interrupt immediately and discards partial progress.
- Handshake: command accepted on cmd_valid & cmd_ready; s_* and m_* use standard valid/ready; a word transfers when both are high.
- Validation at acceptance: len==0, cmd_addr+cmd_len>2048, or a read with cmd_all=1 or a non-one-hot strobe -> err pulses next cycle; state stays IDLE; no cpu_* activity. Writes may use multi-bit strobes (e.g. 7'b1010101).
- States: IDLE -> ARM -> WRITE|READ -> DRAIN (read only) -> FINISH -> IDLE.
- ARM (1 cycle): cpu_interrupt=1; strobe and all latched; cpu_mem_addr=cmd_addr; wr_en=0.
- WRITE: s_ready=1.
  - Each accepted word drives, in the same cycle, wr_en=1, addr=current, and wr_data = s_data with bits [63:60] of lanes 0..6 and all of lane 7 [511:448] forced to 0.
  - Address increments after each word.
  - s_valid low -> wr_en=0 and address holds.
  - After the last word go to FINISH.
- READ:
  - Issue one address per cycle while issued < len and (outstanding + FIFO occupancy) < FIFO_DEPTH.
  - Returned data is captured RD_LAT cycles after issue into the FIFO.
  - m_valid = FIFO not empty; data returns in address order.
  - After the last issue go to DRAIN.
- DRAIN: wait until the outstanding count is 0 and the FIFO is empty, then go to FINISH.
- FINISH (1 cycle): cpu_interrupt=0, wr_en=0, done=1, busy=0 next cycle.
- cpu_interrupt is high from ARM through the last write/drain cycle inclusive.
- cpu_mb_strobe and cpu_mb_all return to 0 in FINISH.
- Address never wraps; the range check guarantees the end address is <= 2047.
- Simultaneous FIFO push and pop in the same cycle keeps occupancy unchanged.
- Latency: command accept T -> ARM T+1 -> first possible write or read issue at T+2.

Test Plan:
- Write, addr 0, len 2048, strobe 7'b1010101, lane k data = i, s_valid always high -> 2048 consecutive wr_en cycles, addr 0..2047, lanes [59:0]=i, bits [63:60] and lane 7 zero, one done pulse, interrupt high for 2049 cycles.
- Write, len 8, s_valid pattern 1,0,0,1... -> wr_en only on valid cycles, address holds across gaps, exactly 8 writes to addr+0..7.
- Read, strobe 7'b0000100, addr 100, len 16, model mem[a]=a, m_ready toggling 1/0 -> m_data sequence 100..115 with no loss or duplication; outstanding+occupancy never exceeds 4.
- Illegal commands: len 0; addr 2040 with len 16; read with strobe 7'b0000011; read with cmd_all=1 -> err pulse for each, cpu_interrupt stays 0, busy stays 0.
- Async rst asserted mid-write at word 500 -> cpu_interrupt, wr_en and busy go 0 without waiting for a clock; a following write of len 4 completes normally.
- Write with cmd_all=1, strobe 7'b0000001, len 2 -> cpu_mb_all=1 throughout ARM/WRITE, 2 writes, done.
